seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Consumes the six 8-bit active-low segment patterns from the scoreboard (team A digits a1..a3,
//  team B digits b1..b3) and time-multiplexes them onto one shared 6-digit common-anode display.
//  Inputs are asynchronous to clk (key-driven scoring logic). The block synchronises them, captures a
//  tear-free snapshot per frame, blanks leading zeros and scans digits with inter-digit dead time.
// PARAMETERS
//  DWELL_CYC   50000  clk cycles each digit is lit (1 ms @ 50 MHz); >= 2
//  BLANK_CYC   500    clk cycles all digits off between digits (anti-ghosting); >= 1
//  LZB         1      1 = leading-zero blanking on a3/a2 and b3/b2; 0 = show all digits
// PORTS
//  clk      in   1   system clock
//  rst      in   1   reset, asynchronous, active-low
//  a1..a3   in   8   team A segment patterns (a1 ones, a3 hundreds), active-low, async domain
//  b1..b3   in   8   team B segment patterns (b1 ones, b3 hundreds), active-low, async domain
//  seg_o    out  8   shared segment bus, active-low {dp,g..a}
//  dig_o    out  6   digit enables, active-low; bit order {b3,b2,b1,a3,a2,a1}
//  frame_o  out  1   1-cycle pulse at end of each full 6-digit scan
// BEHAVIOUR
//  - Reset (async assert, sync release): seg_o=8'hFF, dig_o=6'h3F, frame_o=0, state=BLANK, idx=0,
//    counters=0, snapshot=all 8'hFF. Reset mid-scan aborts immediately to these values.
//  - Sync: each 48-bit input vector passes two flops (s1->s2); s3 holds previous s2 sample.
//  - Snapshot loads from s2 only at frame start (BLANK entry with idx=0) and only if s2==s3 (stable
//    for 2 cycles); otherwise prior snapshot is kept for that frame. Snapshot never changes mid-frame.
//  - FSM: BLANK -> SHOW after BLANK_CYC cycles; SHOW -> BLANK after DWELL_CYC cycles, idx<=idx+1,
//    wrapping 5->0. BLANK: dig_o=6'h3F, seg_o=8'hFF. SHOW: dig_o[idx]=0 others 1, seg_o=disp[idx].
//  - Scan order idx 0..5 = a1,a2,a3,b1,b2,b3. Frame = 6*(BLANK_CYC+DWELL_CYC) cycles.
//  - Outputs registered; seg_o and dig_o change in the same cycle (no glitch between them).
//  - LZB=1: hundreds shown as 8'hFF if ==8'hC0; tens shown as 8'hFF if ==8'hC0 AND hundreds blanked;
//    ones always shown (score 0 displays "  0"). Any non-digit pattern (e.g. 8'hFF) passes unchanged.
//  - frame_o=1 for exactly the cycle of SHOW->BLANK transition with idx=5.
//  - Counter width: $clog2(max(DWELL_CYC,BLANK_CYC)+1); terminal compare is ==cnt-1, no overflow.
// CONFIGURATION
//  - SCAN_DIM_EN defined: extra input dim [2:0] (sync'd, sampled at frame start). In SHOW the digit
//    enable is asserted only while dwell_cnt < ((dim+1)*DWELL_CYC)>>3, else dig_o=6'h3F, seg_o=8'hFF;
//    dim=7 equals full brightness. Scan timing and frame_o unchanged.
//  - SCAN_DIM_EN undefined: no dim port; digit lit for entire dwell.
// STRUCTURE
//  - Package seg_scan_pkg: SEG_BLANK=8'hFF, SEG_ZERO=8'hC0, NUM_DIG=6, scan_state_t {BLANK,SHOW},
//    digit index typedef [2:0].
//  - Sub-module seg_sync_snap: 2-flop synchroniser + stability compare + frame-gated snapshot reg,
//    parameterised on width (48, or 51 with SCAN_DIM_EN). Top holds FSM, counters, LZB, muxing.
// TESTING (DWELL_CYC=8, BLANK_CYC=2, frame=60 cycles)
//  - Reset release, inputs all 8'hC0, LZB=1 -> only idx0/idx3 light, seg_o=8'hC0; other SHOW slots
//    dig_o=6'h3F-equivalent pattern with seg_o=8'hFF; frame_o every 60 cycles.
//  - a3=F9,a2=A4,a1=B0 ("123") -> dig_o=6'h3E/3D/3B in SHOW slots with seg_o=B0/A4/F9; 2 BLANK cycles
//    between each with dig_o=6'h3F.
//  - a3=C0,a2=F9,a1=C0 ("010") -> a3 slot blank (FF), a2 shows F9, a1 shows C0; LZB=0 -> a3 shows C0.
//  - Change b1 mid-frame -> seg_o for b1 unchanged until next frame; toggle b1 every cycle across
//    frame start -> old snapshot retained.
//  - Assert rst during SHOW idx=4 -> same cycle dig_o=6'h3F, seg_o=8'hFF; after release scan restarts idx0.
//  - SCAN_DIM_EN, dim=1 -> each digit lit 2 of 8 dwell cycles; dim=7 -> lit all 8; frame still 60.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the six-digit segment scan driver.
package seg_scan_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_ZERO  = 8'hC0;
   localparam int         NUM_DIG   = 6;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   typedef logic [2:0] dig_idx_t;

   // Replace a pattern by the all-off pattern when its digit is suppressed.
   function automatic logic [7:0] lzb_sel(input logic [7:0] pat, input logic blank);
      return blank ? SEG_BLANK : pat;
   endfunction

endpackage

// File: rtl/seg_sync_snap.sv
// Two-flop synchroniser for a bus from an unrelated domain, plus a snapshot
// register that only takes a new value on load when the synced bus held steady.
module seg_sync_snap #(
   parameter int W = 48
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   input  logic         load,
   output logic [W-1:0] snap
);

   logic [W-1:0] s1;
   logic [W-1:0] s2;
   logic [W-1:0] s3;

   // All-ones reset keeps every digit dark until the first real capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1   <= '1;
         s2   <= '1;
         s3   <= '1;
         snap <= '1;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
         if (load && (s2 == s3)) begin
            snap <= s2;
         end
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes six active-low digit patterns onto one common-anode display
// with leading-zero blanking and dead time. Define SCAN_DIM_EN to add a dim input.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int DWELL_CYC = 50000,
   parameter int BLANK_CYC = 500,
   parameter int LZB       = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  a1,
   input  logic [7:0]  a2,
   input  logic [7:0]  a3,
   input  logic [7:0]  b1,
   input  logic [7:0]  b2,
   input  logic [7:0]  b3,
`ifdef SCAN_DIM_EN
   input  logic [2:0]  dim,
`endif
   output logic [7:0]  seg_o,
   output logic [5:0]  dig_o,
   output logic        frame_o,
   output scan_state_t dbg_state
);

   localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] DW_LAST = CW'(DWELL_CYC - 1);
   localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYC - 1);

   scan_state_t   state, state_n;
   dig_idx_t      idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          frame_end;

   logic [47:0]   snap_seg;
   logic          lit;
   logic [7:0]    seg_d;
   logic [5:0]    dig_d;

`ifdef SCAN_DIM_EN
   logic [50:0]   snap_all;
   logic [2:0]    snap_dim;
   int            lit_lim;

   seg_sync_snap #(.W(51)) u_snap (
      .clk  (clk),
      .rst  (rst),
      .d    ({dim, b3, b2, b1, a3, a2, a1}),
      .load (frame_end),
      .snap (snap_all)
   );
   assign snap_seg = snap_all[47:0];
   assign snap_dim = snap_all[50:48];
`else
   seg_sync_snap #(.W(48)) u_snap (
      .clk  (clk),
      .rst  (rst),
      .d    ({b3, b2, b1, a3, a2, a1}),
      .load (frame_end),
      .snap (snap_seg)
   );
`endif

   // Tens are only suppressed when the hundreds digit is suppressed too.
   logic a_hund_blk, a_tens_blk, b_hund_blk, b_tens_blk;
   assign a_hund_blk = (LZB != 0) && (snap_seg[23:16] == SEG_ZERO);
   assign a_tens_blk = a_hund_blk && (snap_seg[15:8] == SEG_ZERO);
   assign b_hund_blk = (LZB != 0) && (snap_seg[47:40] == SEG_ZERO);
   assign b_tens_blk = b_hund_blk && (snap_seg[39:32] == SEG_ZERO);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= BLANK;
         idx     <= '0;
         cnt     <= '0;
         seg_o   <= SEG_BLANK;
         dig_o   <= 6'h3F;
         frame_o <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         cnt     <= cnt_n;
         seg_o   <= seg_d;
         dig_o   <= dig_d;
         frame_o <= frame_end;
      end
   end

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      cnt_n     = cnt + CW'(1);
      frame_end = 1'b0;
      case (state)
         BLANK: begin
            if (cnt == BL_LAST) begin
               state_n = SHOW;
               cnt_n   = '0;
            end
         end
         SHOW: begin
            if (cnt == DW_LAST) begin
               state_n   = BLANK;
               cnt_n     = '0;
               idx_n     = (idx == dig_idx_t'(NUM_DIG - 1)) ? '0 : idx + 3'd1;
               frame_end = (idx == dig_idx_t'(NUM_DIG - 1));
            end
         end
         default: begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
`ifdef SCAN_DIM_EN
   always_comb begin
      lit_lim = ((int'(snap_dim) + 1) * DWELL_CYC) >>> 3;
      lit     = (state_n == SHOW) && (int'(cnt_n) < lit_lim);
   end
`else
   assign lit = (state_n == SHOW);
`endif

   always_comb begin
      seg_d = SEG_BLANK;
      dig_d = 6'h3F;
      if (lit) begin
         dig_d = ~(6'b000001 << idx_n);
         case (idx_n)
            3'd0:    seg_d = snap_seg[7:0];
            3'd1:    seg_d = lzb_sel(snap_seg[15:8],  a_tens_blk);
            3'd2:    seg_d = lzb_sel(snap_seg[23:16], a_hund_blk);
            3'd3:    seg_d = snap_seg[31:24];
            3'd4:    seg_d = lzb_sel(snap_seg[39:32], b_tens_blk);
            3'd5:    seg_d = lzb_sel(snap_seg[47:40], b_hund_blk);
            default: seg_d = SEG_BLANK;
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DWELL_CYC=8, BLANK_CYC=2 (60-cycle frame),
// running an LZB=1 and an LZB=0 instance side by side on the same inputs.
module tb_seg_scan_driver;
   import seg_scan_pkg::*;

   localparam int DW = 8;
   localparam int BC = 2;

   logic clk = 1'b0;
   logic rst;
   logic [5:0][7:0] in_v;
   logic [7:0] a1, a2, a3, b1, b2, b3;
   logic [2:0] dim;
   logic [7:0] seg_o, seg0_o;
   logic [5:0] dig_o, dig0_o;
   logic       frame_o, frame0_o;
   scan_state_t st, st0;

   assign {b3, b2, b1, a3, a2, a1} = in_v;

   seg_scan_driver #(.DWELL_CYC(DW), .BLANK_CYC(BC), .LZB(1)) dut (
      .clk(clk), .rst(rst),
      .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
`ifdef SCAN_DIM_EN
      .dim(dim),
`endif
      .seg_o(seg_o), .dig_o(dig_o), .frame_o(frame_o), .dbg_state(st)
   );

   seg_scan_driver #(.DWELL_CYC(DW), .BLANK_CYC(BC), .LZB(0)) dut0 (
      .clk(clk), .rst(rst),
      .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
`ifdef SCAN_DIM_EN
      .dim(dim),
`endif
      .seg_o(seg0_o), .dig_o(dig0_o), .frame_o(frame0_o), .dbg_state(st0)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0][7:0] in_v;
      logic [5:0][7:0] exp;
   } vec_t;

   vec_t vecs [4];
   int checks = 0;
   int failures = 0;
   int cur_dim = 7;
   int tog_left = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_frame();
      int n = 0;
      while (frame_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_frame", {31'd0, frame_o}, 32'd1);
   endtask

   // Called at the negedge right after frame_o rose; checks a full frame cycle by cycle.
   task automatic scan_check(input logic [5:0][7:0] exp1, input logic [5:0][7:0] exp0,
                             input int chg_k, input logic [7:0] chg_b1, input int tog_k);
      for (int k = 0; k < 60; k++) begin
         int slot = k / 10;
         int ph = k % 10;
         logic on;
         logic [7:0] eseg, eseg0;
         logic [5:0] edig;
         on = (ph >= 2) && ((ph - 2) < (((cur_dim + 1) * DW) >> 3));
         eseg  = on ? exp1[slot] : 8'hFF;
         eseg0 = on ? exp0[slot] : 8'hFF;
         edig  = on ? ~(6'b000001 << slot) : 6'h3F;
         chk("seg", {24'd0, seg_o}, {24'd0, eseg});
         chk("dig", {26'd0, dig_o}, {26'd0, edig});
         chk("frame", {31'd0, frame_o}, {31'd0, (k == 0)});
         chk("seg_nolzb", {24'd0, seg0_o}, {24'd0, eseg0});
         chk("dig_nolzb", {26'd0, dig0_o}, {26'd0, edig});
         if (k == chg_k) in_v[3] = chg_b1;
         if (k == tog_k) tog_left = 10;
         if (tog_left > 0) begin
            in_v[3] = (in_v[3] == 8'hF9) ? 8'hA4 : 8'hF9;
            tog_left--;
         end
         @(negedge clk);
      end
      chk("frame_period", {31'd0, frame_o}, 32'd1);
   endtask

   task automatic load_and_settle();
      @(negedge clk);
      wait_frame();
      @(negedge clk);
      wait_frame();
   endtask

   logic [5:0][7:0] exp5, raw5;

   initial begin
      vecs[0] = '{in_v: {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0},
                  exp:  {8'hFF, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'hC0}};
      vecs[1] = '{in_v: {8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hB0},
                  exp:  {8'hFF, 8'hFF, 8'hC0, 8'hF9, 8'hA4, 8'hB0}};
      vecs[2] = '{in_v: {8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hC0},
                  exp:  {8'hFF, 8'hC0, 8'hC0, 8'hFF, 8'hF9, 8'hC0}};
      vecs[3] = '{in_v: {8'hA4, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF9},
                  exp:  {8'hA4, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hF9}};
      exp5 = {8'hA4, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hF9};
      raw5 = {8'hA4, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'hF9};

      rst  = 1'b0;
      in_v = vecs[0].in_v;
      dim  = 3'd7;
      repeat (3) @(negedge clk);
      chk("rst_seg", {24'd0, seg_o}, 32'hFF);
      chk("rst_dig", {26'd0, dig_o}, 32'h3F);
      chk("rst_frame", {31'd0, frame_o}, 32'd0);
      chk("rst_state", {31'd0, st}, {31'd0, BLANK});

      rst = 1'b1;
      @(negedge clk);
      chk("rel_blank_dig", {26'd0, dig_o}, 32'h3F);
      @(negedge clk);
      chk("rel_show_dig", {26'd0, dig_o}, 32'h3E);
      chk("rel_show_seg", {24'd0, seg_o}, 32'hFF);
      chk("rel_state", {31'd0, st}, {31'd0, SHOW});

      for (int v = 0; v < 4; v++) begin
         in_v = vecs[v].in_v;
         load_and_settle();
         scan_check(vecs[v].exp, vecs[v].in_v, -1, 8'h00, -1);
      end

      // b1 changes mid-frame: visible only from the following frame.
      scan_check(vecs[3].exp, vecs[3].in_v, 5, 8'hF9, -1);
      // b1 toggles every cycle across the frame boundary: snapshot is kept.
      scan_check(exp5, raw5, -1, 8'h00, 55);
      scan_check(exp5, raw5, -1, 8'h00, -1);

`ifdef SCAN_DIM_EN
      dim = 3'd1;
      load_and_settle();
      cur_dim = 1;
      scan_check(exp5, raw5, -1, 8'h00, -1);
      dim = 3'd7;
      load_and_settle();
      cur_dim = 7;
      scan_check(exp5, raw5, -1, 8'h00, -1);
`endif

      // Reset while digit 4 is lit.
      repeat (45) @(negedge clk);
      chk("pre_rst_dig", {26'd0, dig_o}, 32'h2F);
      chk("pre_rst_seg", {24'd0, seg_o}, {24'd0, exp5[4]});
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_seg", {24'd0, seg_o}, 32'hFF);
      chk("mid_rst_dig", {26'd0, dig_o}, 32'h3F);
      chk("mid_rst_frame", {31'd0, frame_o}, 32'd0);
      chk("mid_rst_dig_nolzb", {26'd0, dig0_o}, 32'h3F);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("restart_blank", {26'd0, dig_o}, 32'h3F);
      @(negedge clk);
      chk("restart_idx0", {26'd0, dig_o}, 32'h3E);
      chk("restart_snap_cleared", {24'd0, seg_o}, 32'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
